// File: rtl/writeback_arbiter_if.sv
//------------------------------------------------------------------------------
// writeback_arbiter_if : ALU/load result inputs and register-file write port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface writeback_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic [31:0] load_rdata;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic        fifo_full;
  logic        fifo_empty;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output load_valid, load_rd, load_funct3, load_addr_lo, load_rdata,
    input  load_ready, reg_write, rd, write_data, pending_mask, fifo_full, fifo_empty
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  load_valid, load_rd, load_funct3, load_addr_lo, load_rdata,
    output load_ready, reg_write, rd, write_data, pending_mask, fifo_full, fifo_empty
  );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter.sv
//------------------------------------------------------------------------------
// writeback_arbiter : merges ALU results and FIFO-buffered load data onto the
//                     register-file write port; ALU has priority.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module writeback_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  writeback_arbiter_if.slave  wb
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

  logic [4:0]            r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]           r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_vld;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic        r_reg_write;
  logic [4:0]  r_rd;
  logic [31:0] r_write_data;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_alu_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext_data;
  logic [31:0] w_mask;

  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_alu_sel = wb.alu_valid && (wb.alu_rd != 5'd0);
  assign w_pop     = !w_alu_sel && !w_empty;
  // Loads to x0 complete the handshake but never occupy a slot.
  assign w_push    = wb.load_valid && wb.load_ready && (wb.load_rd != 5'd0);

  assign wb.load_ready   = !reset && !w_full;
  assign wb.fifo_full    = !reset && w_full;
  assign wb.fifo_empty   = reset || w_empty;
  assign wb.pending_mask = reset ? 32'd0 : w_mask;
  assign wb.reg_write    = r_reg_write;
  assign wb.rd           = r_rd;
  assign wb.write_data   = r_write_data;

  always_comb begin
    w_byte = wb.load_rdata[7:0];
    case (wb.load_addr_lo)
      2'd0:    w_byte = wb.load_rdata[7:0];
      2'd1:    w_byte = wb.load_rdata[15:8];
      2'd2:    w_byte = wb.load_rdata[23:16];
      default: w_byte = wb.load_rdata[31:24];
    endcase
    w_half = wb.load_addr_lo[1] ? wb.load_rdata[31:16] : wb.load_rdata[15:0];
    case (wb.load_funct3)
      3'b000:  w_ext_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext_data = {24'd0, w_byte};
      3'b101:  w_ext_data = {16'd0, w_half};
      default: w_ext_data = wb.load_rdata;
    endcase
  end

  always_comb begin
    w_mask = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_fifo_vld[i]) w_mask[r_fifo_rd[i]] = 1'b1;
    end
    w_mask[0] = 1'b0;
  end

  // Push and pop never share a slot: wptr == rptr only when empty or full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fifo_vld <= '0;
    end else begin
      if (w_push) begin
        r_fifo_rd[r_wptr]   <= wb.load_rd;
        r_fifo_data[r_wptr] <= w_ext_data;
        r_fifo_vld[r_wptr]  <= 1'b1;
        r_wptr              <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_fifo_vld[r_rptr] <= 1'b0;
        r_rptr             <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_write_data <= 32'd0;
    end else if (w_alu_sel) begin
      r_reg_write  <= 1'b1;
      r_rd         <= wb.alu_rd;
      r_write_data <= wb.alu_result;
    end else if (w_pop) begin
      r_reg_write  <= 1'b1;
      r_rd         <= r_fifo_rd[r_rptr];
      r_write_data <= r_fifo_data[r_rptr];
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

endmodule

`default_nettype wire
